// File: rtl/jk_bank_ctrl_if.sv
// Command/response bundle between requesters, the shared jk_ff bank and jk_bank_ctrl.
// The controller takes the slave view; requesters plus the bank take the master view.
interface jk_bank_ctrl_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       req;
    logic [2*N_REQ-1:0]     op_flat;
    logic [WIDTH*N_REQ-1:0] mask_flat;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic [WIDTH-1:0]       j;
    logic [WIDTH-1:0]       k;
    logic [WIDTH-1:0]       q_in;
    logic [WIDTH-1:0]       q_snap;
    logic                   busy;

    modport master (
        output req, op_flat, mask_flat, q_in,
        input  gnt, done, j, k, q_snap, busy
    );

    modport slave (
        input  req, op_flat, mask_flat, q_in,
        output gnt, done, j, k, q_snap, busy
    );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Round-robin arbiter that applies one requester's op/mask to a shared jk_ff bank
// for a single cycle, then returns the sampled bank state with a done pulse.
module jk_bank_ctrl #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    jk_bank_ctrl_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_winner;
    logic [PTR_W-1:0]   w_winner;
    logic [PTR_W-1:0]   w_idx;
    logic               w_found;
    logic [1:0]         w_op_arr   [N_REQ];
    logic [WIDTH-1:0]   w_mask_arr [N_REQ];

    logic [N_REQ-1:0]   w_gnt_nxt;
    logic [N_REQ-1:0]   w_done_nxt;
    logic [WIDTH-1:0]   w_j_nxt;
    logic [WIDTH-1:0]   w_k_nxt;
    logic               w_busy_nxt;

    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_done;
    logic [WIDTH-1:0]   r_j;
    logic [WIDTH-1:0]   r_k;
    logic [WIDTH-1:0]   r_q_snap;
    logic               r_busy;

    // Modulo-N_REQ increment; a < N_REQ and b < N_REQ, so one subtraction suffices.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        s = (s >= N_REQ) ? (s - N_REQ) : s;
        return PTR_W'(s);
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_op_arr[i]   = bus.op_flat[2*i +: 2];
            w_mask_arr[i] = bus.mask_flat[WIDTH*i +: WIDTH];
        end
    end

    // Scan from the highest offset down so the request closest to r_ptr is the last one written.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int o = N_REQ - 1; o >= 0; o--) begin
            w_idx    = wrap_inc(r_ptr, o);
            w_winner = bus.req[w_idx] ? w_idx : w_winner;
            w_found  = w_found | bus.req[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_winner <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_found) begin
                r_ptr    <= wrap_inc(w_winner, 1);
                r_winner <= w_winner;
            end else begin
                r_ptr    <= r_ptr;
                r_winner <= r_winner;
            end
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_state_nxt = w_found ? ST_DRIVE : ST_IDLE;
            ST_DRIVE:  w_state_nxt = ST_SAMPLE;
            ST_SAMPLE: w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        w_gnt_nxt  = '0;
        w_done_nxt = '0;
        w_j_nxt    = '0;
        w_k_nxt    = '0;
        w_busy_nxt = 1'b0;
        case (w_state_nxt)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
            end
            ST_DRIVE: begin
                w_gnt_nxt[w_winner] = 1'b1;
                w_j_nxt    = w_mask_arr[w_winner] & {WIDTH{w_op_arr[w_winner][1]}};
                w_k_nxt    = w_mask_arr[w_winner] & {WIDTH{w_op_arr[w_winner][0]}};
                w_busy_nxt = 1'b1;
            end
            ST_SAMPLE: begin
                w_busy_nxt = 1'b1;
            end
            ST_DONE: begin
                w_done_nxt[r_winner] = 1'b1;
                w_busy_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt    <= '0;
            r_done   <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_q_snap <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_j      <= w_j_nxt;
            r_k      <= w_k_nxt;
            r_busy   <= w_busy_nxt;
            r_q_snap <= (r_state == ST_SAMPLE) ? bus.q_in : r_q_snap;
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.done   = r_done;
    assign bus.j      = r_j;
    assign bus.k      = r_k;
    assign bus.q_snap = r_q_snap;
    assign bus.busy   = r_busy;
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench for jk_bank_ctrl: a jk_ff bank model, a transaction-level
// schedule of expected outputs, directed scenarios and a randomized phase.
module tb_jk_bank_ctrl;
    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int NS    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             bank_rst;
    logic [WIDTH-1:0] bank_q;

    jk_bank_ctrl_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

    jk_bank_ctrl #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.q_in = bank_q;

    // Shared jk_ff bank: q+ = j&~q | ~k&q
    always @(posedge clk) begin
        if (bank_rst) bank_q <= '0;
        else          bank_q <= (bus.j & ~bank_q) | (~bus.k & bank_q);
    end

    // Expected outputs, scheduled per future cycle (slot = cycle mod NS)
    logic [N_REQ-1:0] s_gnt  [NS];
    logic [N_REQ-1:0] s_done [NS];
    logic [WIDTH-1:0] s_j    [NS];
    logic [WIDTH-1:0] s_k    [NS];
    logic [WIDTH-1:0] s_qs   [NS];
    logic             s_busy [NS];
    logic             s_qsv  [NS];
    logic [WIDTH-1:0] exp_qsnap;

    int cyc;
    int m_ptr;
    int m_free;
    int n_cmp;
    int n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s cyc=%0d actual=timeout expected=event", name, cyc);
    endtask

    function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] q,
                                                  input logic [1:0] op,
                                                  input logic [WIDTH-1:0] m);
        case (op)
            2'b01:   return q & ~m;
            2'b10:   return q | m;
            2'b11:   return q ^ m;
            default: return q;
        endcase
    endfunction

    task automatic clear_slot(input int c);
        int s;
        s = c % NS;
        s_gnt[s] = '0; s_done[s] = '0; s_j[s] = '0; s_k[s] = '0;
        s_qs[s] = '0; s_busy[s] = 1'b0; s_qsv[s] = 1'b0;
    endtask

    // Decide what the edge ending cycle cyc does, and schedule the consequences.
    task automatic model_step();
        int w;
        logic [1:0]       op;
        logic [WIDTH-1:0] m;
        if (rst) begin
            for (int d = 1; d <= 3; d++) clear_slot(cyc + d);
            s_qsv[(cyc+1)%NS] = 1'b1;
            s_qs[(cyc+1)%NS]  = '0;
            m_ptr  = 0;
            m_free = cyc + 1;
        end else if (cyc >= m_free && bus.req != '0) begin
            w = -1;
            for (int o = 0; o < N_REQ; o++)
                if (w < 0 && bus.req[(m_ptr + o) % N_REQ]) w = (m_ptr + o) % N_REQ;
            op = bus.op_flat[2*w +: 2];
            m  = bus.mask_flat[WIDTH*w +: WIDTH];
            s_gnt[(cyc+1)%NS]  = N_REQ'(1) << w;
            s_j[(cyc+1)%NS]    = m & {WIDTH{op[1]}};
            s_k[(cyc+1)%NS]    = m & {WIDTH{op[0]}};
            s_busy[(cyc+1)%NS] = 1'b1;
            s_busy[(cyc+2)%NS] = 1'b1;
            s_busy[(cyc+3)%NS] = 1'b1;
            s_done[(cyc+3)%NS] = N_REQ'(1) << w;
            s_qsv[(cyc+3)%NS]  = 1'b1;
            s_qs[(cyc+3)%NS]   = apply_op(bank_q, op, m);
            m_ptr  = (w + 1) % N_REQ;
            m_free = cyc + 4;
        end
    endtask

    // One clock cycle: compare at the falling edge, step the model, advance past the rising edge.
    task automatic tick();
        int s;
        @(negedge clk);
        s = cyc % NS;
        if (s_qsv[s]) exp_qsnap = s_qs[s];
        check("gnt",    32'(bus.gnt),    32'(s_gnt[s]));
        check("done",   32'(bus.done),   32'(s_done[s]));
        check("j",      32'(bus.j),      32'(s_j[s]));
        check("k",      32'(bus.k),      32'(s_k[s]));
        check("busy",   32'(bus.busy),   32'(s_busy[s]));
        check("q_snap", 32'(bus.q_snap), 32'(exp_qsnap));
        clear_slot(cyc);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 12) begin tick(); n++; end
        if (bus.busy) timeout_fail("wait_idle");
    endtask

    task automatic tick_until_gnt(output logic ok);
        int n;
        ok = 1'b0;
        for (n = 0; n < 12 && !ok; n++) begin tick(); ok = (bus.gnt != '0); end
        if (!ok) timeout_fail("wait_gnt");
    endtask

    task automatic tick_until_done(output logic ok);
        int n;
        ok = 1'b0;
        for (n = 0; n < 12 && !ok; n++) begin tick(); ok = (bus.done != '0); end
        if (!ok) timeout_fail("wait_done");
    endtask

    // Single command from an idle controller; returns what was seen on gnt/j/k/done/q_snap.
    task automatic run_cmd(input int idx, input logic [1:0] op, input logic [WIDTH-1:0] m,
                           output logic [N_REQ-1:0] g, output logic [WIDTH-1:0] jj,
                           output logic [WIDTH-1:0] kk, output logic [N_REQ-1:0] d,
                           output logic [WIDTH-1:0] qs, output int lat_g, output int lat_d);
        int  c0;
        logic ok;
        wait_idle();
        bus.req = '0;
        bus.req[idx] = 1'b1;
        bus.op_flat[2*idx +: 2] = op;
        bus.mask_flat[WIDTH*idx +: WIDTH] = m;
        c0 = cyc;
        tick_until_gnt(ok);
        g = bus.gnt; jj = bus.j; kk = bus.k; lat_g = cyc - c0;
        bus.req = '0;
        tick_until_done(ok);
        d = bus.done; qs = bus.q_snap; lat_d = cyc - c0;
    endtask

    int               gq[$];
    int               gc[$];
    logic [N_REQ-1:0] g, d;
    logic [WIDTH-1:0] jj, kk, qs;
    int               lg, ld;
    logic             ok;

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; m_ptr = 0; m_free = 0;
        exp_qsnap = '0;
        for (int i = 0; i < NS; i++) clear_slot(i);
        rst = 1'b1; bank_rst = 1'b1;
        bus.req = 4'b1111; bus.op_flat = '0; bus.mask_flat = 32'h5A3C_96E1;

        // Reset with all requests asserted
        tick();
        tick();
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_qsnap", 32'(bus.q_snap), 32'h0);
        rst = 1'b0; bank_rst = 1'b0;

        // Continuous all-request: round-robin order and 4-cycle spacing
        for (int n = 0; n < 20; n++) begin
            tick();
            for (int i = 0; i < N_REQ; i++)
                if (bus.gnt[i]) begin gq.push_back(i); gc.push_back(cyc); end
        end
        if (gq.size() < 5) timeout_fail("rr_count");
        else begin
            check("rr_g0", 32'(gq[0]), 32'd0);
            check("rr_g1", 32'(gq[1]), 32'd1);
            check("rr_g2", 32'(gq[2]), 32'd2);
            check("rr_g3", 32'(gq[3]), 32'd3);
            check("rr_g4", 32'(gq[4]), 32'd0);
            for (int i = 1; i < 5; i++) check("rr_gap", 32'(gc[i] - gc[i-1]), 32'd4);
        end
        bus.req = '0;
        wait_idle();
        bank_rst = 1'b1;
        tick();
        bank_rst = 1'b0;

        // Set on requester 2 from an empty bank
        run_cmd(2, 2'b10, 8'h0F, g, jj, kk, d, qs, lg, ld);
        check("set_gnt", 32'(g), 32'h4);
        check("set_j", 32'(jj), 32'h0F);
        check("set_k", 32'(kk), 32'h0);
        check("set_done", 32'(d), 32'h4);
        check("set_qsnap", 32'(qs), 32'h0F);
        check("set_lat_gnt", 32'(lg), 32'd1);
        check("set_lat_done", 32'(ld), 32'd3);

        // Toggle all, then clear the upper nibble
        run_cmd(1, 2'b11, 8'hFF, g, jj, kk, d, qs, lg, ld);
        check("tog_j", 32'(jj), 32'hFF);
        check("tog_k", 32'(kk), 32'hFF);
        check("tog_qsnap", 32'(qs), 32'hF0);
        run_cmd(3, 2'b01, 8'hF0, g, jj, kk, d, qs, lg, ld);
        check("clr_j", 32'(jj), 32'h00);
        check("clr_qsnap", 32'(qs), 32'h00);

        // Wrap-around: ptr=3, req[3] drops as req[0] rises
        run_cmd(2, 2'b10, 8'h01, g, jj, kk, d, qs, lg, ld);
        bus.req = 4'b0100;
        bus.op_flat = '0;
        tick_until_gnt(ok);
        bus.req = 4'b1000;
        tick_until_done(ok);
        bus.req = 4'b0001;
        tick_until_gnt(ok);
        check("wrap_gnt", 32'(bus.gnt), 32'h1);
        bus.req = 4'b0011;
        tick_until_gnt(ok);
        check("ptr_after_wrap", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        wait_idle();

        // Reset during SAMPLE of a toggle, request left pending
        bus.req = 4'b0100;
        bus.op_flat[5:4] = 2'b11;
        bus.mask_flat[23:16] = 8'hAA;
        tick_until_gnt(ok);
        tick();
        rst = 1'b1;
        tick();
        check("abort_done", 32'(bus.done), 32'h0);
        check("abort_qsnap", 32'(bus.q_snap), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        tick_until_gnt(ok);
        check("regrant", 32'(bus.gnt), 32'h4);
        bus.req = '0;
        wait_idle();

        // Randomized traffic with occasional reset
        for (int n = 0; n < 600; n++) begin
            tick();
            rst = ($urandom_range(0, 79) == 0);
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.gnt[i]) bus.req[i] = 1'b0;
                else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.op_flat[2*i +: 2] = 2'($urandom_range(0, 3));
                    bus.mask_flat[WIDTH*i +: WIDTH] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                end
            end
        end
        rst = 1'b0;
        bus.req = '0;
        for (int n = 0; n < 6; n++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
